rom_reader: RTL and testbench

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader_pkg.sv | 17 +
 rtl/rom_reader_if.sv | 37 +++
 rtl/rom_wait_counter.sv | 28 ++
 rtl/rom_reader.sv | 130 +++++++++++++
 tb/tb_rom_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_reader_pkg.sv
// Shared widths, limits and FSM state type for the EPROM read controller.
package rom_reader_pkg;
  localparam int ROM_ADDR_W = 12;
  localparam int ROM_DATA_W = 8;
  localparam int WAIT_MAX   = 15;
  localparam int WAIT_W     = 4;

  localparam logic [WAIT_W-1:0] WAIT_ZERO = 4'd0;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } rom_rd_state_t;
endpackage

// File: rtl/rom_reader_if.sv
// Request/response and EPROM pin bundle for rom_reader.
// ROM_READER_CHECKSUM_EN adds the csum/csum_clr signals.
interface rom_reader_if;
  import rom_reader_pkg::*;

  logic                  req;
  logic [ROM_ADDR_W-1:0] addr;
  logic                  rdy;
  logic                  valid;
  logic [ROM_DATA_W-1:0] data;
  logic                  rom_e;
  logic                  rom_g;
  logic [ROM_ADDR_W-1:0] rom_a;
  logic [ROM_DATA_W-1:0] rom_q;
`ifdef ROM_READER_CHECKSUM_EN
  logic [ROM_DATA_W-1:0] csum;
  logic                  csum_clr;
`endif

  modport slave (
    input  req, addr, rom_q,
`ifdef ROM_READER_CHECKSUM_EN
    input  csum_clr,
    output csum,
`endif
    output rdy, valid, data, rom_e, rom_g, rom_a
  );

  modport master (
    output req, addr, rom_q,
`ifdef ROM_READER_CHECKSUM_EN
    output csum_clr,
    input  csum,
`endif
    input  rdy, valid, data, rom_e, rom_g, rom_a
  );
endinterface

// File: rtl/rom_wait_counter.sv
// Access-time down counter: loads a start value, counts down to zero and stops.
module rom_wait_counter
  import rom_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);
  logic [WAIT_W-1:0] count_r;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= WAIT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != WAIT_ZERO)) begin
      count_r <= count_r - WAIT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == WAIT_ZERO);
endmodule

// File: rtl/rom_reader.sv
// EPROM read controller: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> RECOVER.
// ROM_READER_CHECKSUM_EN adds a running mod-256 checksum of captured bytes.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input logic         clk,
  input logic         rst,
  rom_reader_if.slave bus
);
  if ((WAIT_CYCLES < 32'd1) || (WAIT_CYCLES > WAIT_MAX)) begin : g_bad_wait
    $error("rom_reader: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(WAIT_CYCLES - 32'd1);

  rom_rd_state_t         state_r, state_s;
  logic                  zero_s, load_s, dec_s, capture_s, accept_s;
  logic                  rdy_s, rom_e_s, rom_g_s, valid_s;
  logic                  rdy_r, rom_e_r, rom_g_r, valid_r;
  logic [ROM_ADDR_W-1:0] rom_a_r;
  logic [ROM_DATA_W-1:0] data_r;

  assign accept_s  = (state_r == ST_IDLE) && bus.req;
  assign load_s    = (state_r == ST_SETUP);
  assign dec_s     = (state_r == ST_ACCESS) && !zero_s;
  assign capture_s = (state_r == ST_ACCESS) && zero_s;

  rom_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .dec      (dec_s),
    .load_val (LOAD_VAL),
    .zero     (zero_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req) state_s = ST_SETUP;
        else         state_s = ST_IDLE;
      end
      ST_SETUP:  state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (zero_s) state_s = ST_RECOVER;
        else        state_s = ST_ACCESS;
      end
      ST_RECOVER: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    rdy_s   = 1'b0;
    rom_e_s = 1'b1;
    rom_g_s = 1'b1;
    valid_s = 1'b0;
    case (state_s)
      ST_IDLE:    rdy_s   = 1'b1;
      ST_SETUP:   rom_e_s = 1'b0;
      ST_ACCESS: begin
        rom_e_s = 1'b0;
        rom_g_s = 1'b0;
      end
      ST_RECOVER: valid_s = 1'b1;
      default:    rdy_s   = 1'b1;
    endcase
  end

  // Output registers; address latched on acceptance, byte on ACCESS exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_r   <= 1'b1;
      rom_e_r <= 1'b1;
      rom_g_r <= 1'b1;
      valid_r <= 1'b0;
      rom_a_r <= {ROM_ADDR_W{1'b0}};
      data_r  <= {ROM_DATA_W{1'b0}};
    end else begin
      rdy_r   <= rdy_s;
      rom_e_r <= rom_e_s;
      rom_g_r <= rom_g_s;
      valid_r <= valid_s;
      rom_a_r <= accept_s  ? bus.addr  : rom_a_r;
      data_r  <= capture_s ? bus.rom_q : data_r;
    end
  end

  assign bus.rdy   = rdy_r;
  assign bus.rom_e = rom_e_r;
  assign bus.rom_g = rom_g_r;
  assign bus.valid = valid_r;
  assign bus.rom_a = rom_a_r;
  assign bus.data  = data_r;

`ifdef ROM_READER_CHECKSUM_EN
  logic [ROM_DATA_W-1:0] csum_r;

  // A clear coinciding with a capture restarts the sum from that byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_r <= {ROM_DATA_W{1'b0}};
    end else if (capture_s && bus.csum_clr) begin
      csum_r <= bus.rom_q;
    end else if (capture_s) begin
      csum_r <= csum_r + bus.rom_q;
    end else if (bus.csum_clr) begin
      csum_r <= {ROM_DATA_W{1'b0}};
    end else begin
      csum_r <= csum_r;
    end
  end

  assign bus.csum = csum_r;
`endif
endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: read-timeline reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_rom_reader;
  localparam int WAIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic check_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] mem [0:4095];

  rom_reader_if bus ();

  rom_reader #(.WAIT_CYCLES(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // EPROM model: drives the addressed byte only while output-enabled.
  assign bus.rom_q = bus.rom_g ? 8'h00 : mem[bus.rom_a];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: t_m = clocks since acceptance, -1 when idle.
  int         t_m;
  logic [11:0] a_m;
  logic [7:0]  data_m;
  logic [7:0]  csum_m;

  always @(posedge clk) begin
    if (rst) begin
      t_m    <= -1;
      a_m    <= 12'h000;
      data_m <= 8'h00;
      csum_m <= 8'h00;
    end else begin
      if (t_m < 0) begin
        if (bus.req) begin
          t_m <= 0;
          a_m <= bus.addr;
        end
      end else if (t_m == WAIT + 1) begin
        t_m <= -1;
      end else begin
        t_m <= t_m + 1;
      end
      if (t_m == WAIT) data_m <= mem[a_m];
`ifdef ROM_READER_CHECKSUM_EN
      if (t_m == WAIT && bus.csum_clr) csum_m <= mem[a_m];
      else if (t_m == WAIT)            csum_m <= csum_m + mem[a_m];
      else if (bus.csum_clr)           csum_m <= 8'h00;
`endif
    end
  end

  logic [23:0] exp_vec;
  logic [23:0] act_vec;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      exp_vec = {(t_m < 0), (t_m == WAIT + 1), !(t_m >= 0 && t_m <= WAIT),
                 !(t_m >= 1 && t_m <= WAIT), a_m, data_m};
      act_vec = {bus.rdy, bus.valid, bus.rom_e, bus.rom_g, bus.rom_a, bus.data};
      chk("model_rdy_valid_e_g_a_data", act_vec, exp_vec);
      chk("g_low_needs_e_low", {31'd0, (bus.rom_g | ~bus.rom_e)}, 32'd1);
`ifdef ROM_READER_CHECKSUM_EN
      chk("model_csum", {24'd0, bus.csum}, {24'd0, csum_m});
`endif
    end
  end

  task automatic do_read(input logic [11:0] a, input logic clr_cap,
                         output int e_low, output int g_low, output int valid_k,
                         output int valid_cnt, output logic [7:0] d, output logic a_stable);
    bus.req  = 1'b1;
    bus.addr = a;
    @(posedge clk);
    e_low = 0; g_low = 0; valid_k = -1; valid_cnt = 0; d = 8'h00; a_stable = 1'b1;
    for (int k = 0; k <= WAIT + 2; k++) begin
      @(negedge clk);
      if (!bus.rom_e) e_low++;
      if (!bus.rom_g) g_low++;
      if (bus.valid) begin
        valid_cnt++;
        valid_k = k;
        d = bus.data;
      end
      if (bus.rom_a !== a) a_stable = 1'b0;
      if (k == 0) bus.req = 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
      if (k == WAIT) bus.csum_clr = clr_cap;
      if (k == WAIT + 1) bus.csum_clr = 1'b0;
`endif
    end
  endtask

  int          e_low, g_low, vk, vcnt, v0, v1;
  logic [7:0]  d, d0, d1;
  logic        a_ok;

  initial begin
    bus.req  = 1'b0;
    bus.addr = 12'h000;
`ifdef ROM_READER_CHECKSUM_EN
    bus.csum_clr = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;

    // Reset held two cycles.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    chk("reset_state", {bus.rom_e, bus.rom_g, bus.rdy, bus.valid, bus.data, bus.rom_a},
        {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 12'h000});
    rst = 1'b0;

    // Single read of 0x123.
    mem[12'h123] = 8'hA5;
    do_read(12'h123, 1'b0, e_low, g_low, vk, vcnt, d, a_ok);
    chk("single_e_low_cycles", e_low, 32'd4);
    chk("single_g_low_cycles", g_low, 32'd3);
    chk("single_valid_delay", vk, 32'd4);
    chk("single_valid_count", vcnt, 32'd1);
    chk("single_data", {24'd0, d}, 32'h0000_00A5);
    chk("single_addr_stable", {31'd0, a_ok}, 32'd1);

    // REQ held high, two back-to-back reads from the erased device.
    bus.req = 1'b1;
    bus.addr = 12'h000;
    mem[12'h123] = 8'hFF;
    @(posedge clk);
    v0 = -1; v1 = -1; vcnt = 0; d0 = 8'h00; d1 = 8'h00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.valid) begin
        if (vcnt == 0) begin v0 = k; d0 = bus.data; end
        else           begin v1 = k; d1 = bus.data; end
        vcnt++;
      end
      if (k == 0) bus.addr = 12'hFFF;
      if (k == 11) begin
        chk("b2b_second_addr", {20'd0, bus.rom_a}, 32'h0000_0FFF);
        bus.req = 1'b0;
      end
    end
    chk("b2b_valid_count", vcnt, 32'd2);
    chk("b2b_valid_spacing", v1 - v0, 32'd6);
    chk("b2b_data_first", {24'd0, d0}, 32'h0000_00FF);
    chk("b2b_data_second", {24'd0, d1}, 32'h0000_00FF);

    // REQ/ADDR disturbed during ACCESS must be ignored.
    mem[12'h123] = 8'hA5;
    bus.req = 1'b1;
    bus.addr = 12'h123;
    @(posedge clk);
    vcnt = 0; a_ok = 1'b1; d = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.valid) begin vcnt++; d = bus.data; end
      if (bus.rom_a !== 12'h123) a_ok = 1'b0;
      case (k)
        0: bus.req = 1'b0;
        1: begin bus.req = 1'b1; bus.addr = 12'h456; end
        2: bus.req = 1'b0;
        3: bus.req = 1'b1;
        4: bus.req = 1'b0;
        default: bus.req = 1'b0;
      endcase
    end
    chk("ignore_addr_held", {31'd0, a_ok}, 32'd1);
    chk("ignore_valid_count", vcnt, 32'd1);
    chk("ignore_data", {24'd0, d}, 32'h0000_00A5);

    // Reset during the second ACCESS cycle aborts the read.
    bus.req = 1'b1;
    bus.addr = 12'h123;
    @(posedge clk);
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 3 && bus.valid) vcnt++;
      if (k == 0) bus.req = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        chk("abort_pins", {bus.rom_e, bus.rom_g, bus.rdy, bus.valid}, {28'd0, 4'b1110});
        rst = 1'b0;
      end
    end
    chk("abort_no_valid", vcnt, 32'd0);
    chk("abort_data_reset", {24'd0, bus.data}, 32'h0000_0000);

`ifdef ROM_READER_CHECKSUM_EN
    mem[12'h001] = 8'h01;
    mem[12'h002] = 8'h02;
    mem[12'h003] = 8'hFF;
    mem[12'h004] = 8'h7E;
    mem[12'h005] = 8'h10;
    do_read(12'h001, 1'b0, e_low, g_low, vk, vcnt, d, a_ok);
    do_read(12'h002, 1'b0, e_low, g_low, vk, vcnt, d, a_ok);
    do_read(12'h003, 1'b0, e_low, g_low, vk, vcnt, d, a_ok);
    chk("csum_sum", {24'd0, bus.csum}, 32'h0000_0002);
    bus.csum_clr = 1'b1;
    @(negedge clk);
    bus.csum_clr = 1'b0;
    chk("csum_clear", {24'd0, bus.csum}, 32'h0000_0000);
    do_read(12'h005, 1'b0, e_low, g_low, vk, vcnt, d, a_ok);
    do_read(12'h004, 1'b1, e_low, g_low, vk, vcnt, d, a_ok);
    chk("csum_clear_with_capture", {24'd0, bus.csum}, 32'h0000_007E);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 99) == 0);
      bus.req  = 1'($urandom);
      bus.addr = 12'($urandom);
`ifdef ROM_READER_CHECKSUM_EN
      bus.csum_clr = ($urandom_range(0, 7) == 0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req = 1'b0;
    repeat (8) @(negedge clk);
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
